bus_key_sequencer: RTL and testbench

Parametrised bus-snooping unlock sequencer for the board-control PLD slot. It watches qualified read cycles in a decoded address window and advances through a programmable key of address-field values. On a complete key it enters an unlocked state and returns a pseudo-random response stream on a tristate readback bit. It generalises the fixed single-key 6-flop sequencer with configurable key length and field position, a mismatch mode, a timed lockout and a relock access.

---
 rtl/bus_key_sequencer_if.sv | 27 ++
 rtl/bus_key_sequencer.sv | 125 ++++++++++++
 tb/tb_bus_key_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_key_sequencer_if.sv
// Bus-side signal bundle for bus_key_sequencer: snooped bus cycle inputs
// plus status and tristate readback outputs.
`timescale 1ns/1ps
interface bus_key_sequencer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              sel_n;
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              strobe;
  logic              oe_n;
  logic              unlocked;
  logic [3:0]        step;
  logic              locked_out;
  logic              rd_data;
  logic              rd_data_oe;

  modport master (
    output sel_n, addr, rd, strobe, oe_n,
    input  unlocked, step, locked_out, rd_data, rd_data_oe
  );

  modport slave (
    input  sel_n, addr, rd, strobe, oe_n,
    output unlocked, step, locked_out, rd_data, rd_data_oe
  );
endinterface

// File: rtl/bus_key_sequencer.sv
// Bus-snooping unlock sequencer: qualified reads in an address window walk a
// programmable key; a full key unlocks an LFSR response stream on rd_data.
`timescale 1ns/1ps
module bus_key_sequencer #(
  parameter int unsigned              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]        WIN_MASK    = 16'h3000,
  parameter logic [ADDR_W-1:0]        WIN_MATCH   = 16'h1000,
  parameter int unsigned              KEY_LSB     = 4,
  parameter int unsigned              KEY_W       = 4,
  parameter int unsigned              KEY_LEN     = 4,
  parameter logic [KEY_LEN*KEY_W-1:0] KEY         = 16'h2A5B,
  parameter logic [KEY_W-1:0]         RELOCK      = 4'hF,
  parameter bit                       MODE        = 1'b0,
  parameter int unsigned              LOCKOUT_CYC = 64,
  parameter logic [7:0]               LFSR_SEED   = 8'hA5
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_key_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SEQ, S_UNLOCKED, S_LOCKOUT} state_t;

  localparam int unsigned      CNT_W     = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [3:0]       LAST_STEP = 4'(KEY_LEN - 1);
  localparam logic [KEY_W-1:0] KEY0      = KEY[KEY_W-1:0];

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_step,  w_step_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [7:0]       r_lfsr,  w_lfsr_nxt;

  logic             w_q;
  logic [KEY_W-1:0] w_f;
  logic [KEY_W-1:0] w_key_cur;
  logic             w_fb;

  assign w_q  = bus.strobe & ~bus.sel_n & bus.rd & ((bus.addr & WIN_MASK) == WIN_MATCH);
  assign w_f  = bus.addr[KEY_LSB +: KEY_W];
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_key_cur = KEY0;
    for (int unsigned k = 0; k < KEY_LEN; k++) begin
      if (r_step == 4'(k)) w_key_cur = KEY[k*KEY_W +: KEY_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    unique case (r_state)
      S_IDLE, S_SEQ: begin
        if (w_q) begin
          if (w_f == w_key_cur) begin
            if (r_step == LAST_STEP) begin
              w_state_nxt = S_UNLOCKED;
              w_step_nxt  = '0;
              w_lfsr_nxt  = LFSR_SEED;
            end else begin
              w_state_nxt = S_SEQ;
              w_step_nxt  = r_step + 4'd1;
            end
          end else if (!MODE) begin
            w_state_nxt = S_LOCKOUT;
            w_step_nxt  = '0;
            w_cnt_nxt   = CNT_LOAD;
          end else if (r_state == S_SEQ && w_f == KEY0) begin
            // restart mode: the failing digit may itself open a new attempt
            w_step_nxt = 4'd1;
          end else begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = '0;
          end
        end
      end
      S_UNLOCKED: begin
        if (w_q) begin
          if (w_f == RELOCK) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_lfsr_nxt = {r_lfsr[6:0], w_fb};
          end
        end
      end
      S_LOCKOUT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_step_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    bus.unlocked   = (r_state == S_UNLOCKED) & ~bus.oe_n;
    bus.step       = bus.oe_n ? 4'd0 : r_step;
    bus.locked_out = (r_state == S_LOCKOUT);
    bus.rd_data_oe = w_q;
    bus.rd_data    = (r_state == S_UNLOCKED) ? r_lfsr[7] : ^r_step;
  end

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Self-checking bench for bus_key_sequencer: strict-mode and restart-mode
// instances share stimulus; expectations flow through a scoreboard queue.
`timescale 1ns/1ps
module tb_bus_key_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        t_stb, t_seln, t_rd, t_oen;
  logic [15:0] t_addr;
  logic        dsel;
  int          n_cmp, n_bad;

  always #5 clk = ~clk;

  bus_key_sequencer_if #(.ADDR_W(16)) bus0 ();
  bus_key_sequencer_if #(.ADDR_W(16)) bus1 ();

  assign bus0.strobe = t_stb;  assign bus1.strobe = t_stb;
  assign bus0.sel_n  = t_seln; assign bus1.sel_n  = t_seln;
  assign bus0.rd     = t_rd;   assign bus1.rd     = t_rd;
  assign bus0.addr   = t_addr; assign bus1.addr   = t_addr;
  assign bus0.oe_n   = t_oen;  assign bus1.oe_n   = t_oen;

  bus_key_sequencer #(.MODE(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bus_key_sequencer #(.MODE(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    string       name;
    bit          stb, seln, rd;
    logic [15:0] addr;
    bit          oen;
    bit          e_oe, e_rdd;
    logic [3:0]  e_step;
    bit          e_unl, e_lck;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input string n, input bit stb, input bit seln, input bit rd,
                              input logic [15:0] a, input bit oen, input bit e_oe,
                              input bit e_rdd, input logic [3:0] e_step, input bit e_unl,
                              input bit e_lck);
    vec_t v;
    v.name = n; v.stb = stb; v.seln = seln; v.rd = rd; v.addr = a; v.oen = oen;
    v.e_oe = e_oe; v.e_rdd = e_rdd; v.e_step = e_step; v.e_unl = e_unl; v.e_lck = e_lck;
    return v;
  endfunction

  function automatic logic [7:0] lnext(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic chk(input logic [3:0] act);
    sb_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0h required an expectation", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h required %0h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    t_stb = v.stb; t_seln = v.seln; t_rd = v.rd; t_addr = v.addr; t_oen = v.oen;
    sb.push_back('{{v.name, ".rd_data_oe"}, {3'b0, v.e_oe}});
    sb.push_back('{{v.name, ".rd_data"},    {3'b0, v.e_rdd}});
    sb.push_back('{{v.name, ".step"},       v.e_step});
    sb.push_back('{{v.name, ".unlocked"},   {3'b0, v.e_unl}});
    sb.push_back('{{v.name, ".locked_out"}, {3'b0, v.e_lck}});
    @(negedge clk);
    chk({3'b0, dsel ? bus1.rd_data_oe : bus0.rd_data_oe});
    chk({3'b0, dsel ? bus1.rd_data    : bus0.rd_data});
    @(posedge clk); #1;
    chk(dsel ? bus1.step : bus0.step);
    chk({3'b0, dsel ? bus1.unlocked   : bus0.unlocked});
    chk({3'b0, dsel ? bus1.locked_out : bus0.locked_out});
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  // Key digits in step order are B,5,A,2 (low nibble of KEY first); field is addr[7:4].
  task automatic full_key(input string n);
    apply(mk({n, "_k0"}, 1, 0, 1, 16'h10B0, 0, 1, 0, 4'd1, 0, 0));
    apply(mk({n, "_k1"}, 1, 0, 1, 16'h1050, 0, 1, 1, 4'd2, 0, 0));
    apply(mk({n, "_k2"}, 1, 0, 1, 16'h10A0, 0, 1, 1, 4'd3, 0, 0));
    apply(mk({n, "_k3"}, 1, 0, 1, 16'h1020, 0, 1, 0, 4'd0, 1, 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] lf;
    n_cmp = 0; n_bad = 0; dsel = 1'b0;
    rst_n = 1'b0;
    t_stb = 0; t_seln = 1; t_rd = 0; t_addr = '0; t_oen = 0;
    repeat (2) @(posedge clk); #1;
    apply(mk("reset", 0, 1, 0, 16'h0000, 0, 0, 0, 4'd0, 0, 0));
    rst_n = 1'b1;

    // key entry interleaved with accesses that must be ignored
    tbl.push_back(mk("k0",        1, 0, 1, 16'h10B0, 0, 1, 0, 4'd1, 0, 0));
    tbl.push_back(mk("write",     1, 0, 0, 16'h1050, 0, 0, 1, 4'd1, 0, 0));
    tbl.push_back(mk("desel",     1, 1, 1, 16'h1050, 0, 0, 1, 4'd1, 0, 0));
    tbl.push_back(mk("win_3xxx",  1, 0, 1, 16'h3050, 0, 0, 1, 4'd1, 0, 0));
    tbl.push_back(mk("win_0xxx",  1, 0, 1, 16'h0050, 0, 0, 1, 4'd1, 0, 0));
    tbl.push_back(mk("no_strobe", 0, 0, 1, 16'h1050, 0, 0, 1, 4'd1, 0, 0));
    tbl.push_back(mk("k1",        1, 0, 1, 16'h1050, 0, 1, 1, 4'd2, 0, 0));
    tbl.push_back(mk("oe_gate_s", 0, 0, 1, 16'h1000, 1, 0, 1, 4'd0, 0, 0));
    tbl.push_back(mk("k2",        1, 0, 1, 16'h10A0, 0, 1, 1, 4'd3, 0, 0));
    tbl.push_back(mk("k3",        1, 0, 1, 16'h1020, 0, 1, 0, 4'd0, 1, 0));
    tbl.push_back(mk("oe_gate_u", 0, 0, 1, 16'h1000, 1, 0, 1, 4'd0, 0, 0));
    tbl.push_back(mk("unl_idle",  0, 0, 1, 16'h1000, 0, 0, 1, 4'd0, 1, 0));
    run_tbl();

    lf = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      apply(mk("resp", 1, 0, 1, 16'h1000, 0, 1, lf[7], 4'd0, 1, 0));
      lf = lnext(lf);
    end
    apply(mk("relock", 1, 0, 1, 16'h10F0, 0, 1, lf[7], 4'd0, 0, 0));

    full_key("reunlock");
    lf = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      apply(mk("resp_reseed", 1, 0, 1, 16'h1040, 0, 1, lf[7], 4'd0, 1, 0));
      lf = lnext(lf);
    end
    apply(mk("relock2", 1, 0, 1, 16'h10F0, 0, 1, lf[7], 4'd0, 0, 0));

    apply(mk("pre_rst0", 1, 0, 1, 16'h10B0, 0, 1, 0, 4'd1, 0, 0));
    apply(mk("pre_rst1", 1, 0, 1, 16'h1050, 0, 1, 1, 4'd2, 0, 0));
    rst_n = 1'b0;
    apply(mk("rst_mid",  1, 0, 1, 16'h10A0, 0, 1, 1, 4'd0, 0, 0));
    rst_n = 1'b1;

    // strict mode: mismatch at step 2 holds off for exactly 64 cycles
    apply(mk("lk_k0",  1, 0, 1, 16'h10B0, 0, 1, 0, 4'd1, 0, 0));
    apply(mk("lk_k1",  1, 0, 1, 16'h1050, 0, 1, 1, 4'd2, 0, 0));
    apply(mk("lk_bad", 1, 0, 1, 16'h1070, 0, 1, 1, 4'd0, 0, 1));
    for (int i = 1; i <= 64; i++) begin
      apply(mk("lk_hold", 1, 0, 1, 16'h10B0, (i == 10), 1, 0, 4'd0, 0, (i < 64)));
    end
    apply(mk("lk_after", 1, 0, 1, 16'h10B0, 0, 1, 0, 4'd1, 0, 0));

    // restart-mode instance
    rst_n = 1'b0;
    dsel  = 1'b1;
    repeat (2) @(posedge clk); #1;
    apply(mk("m1_reset", 0, 1, 0, 16'h0000, 0, 0, 0, 4'd0, 0, 0));
    rst_n = 1'b1;
    tbl.push_back(mk("m1_k0",    1, 0, 1, 16'h10B0, 0, 1, 0, 4'd1, 0, 0));
    tbl.push_back(mk("m1_k1",    1, 0, 1, 16'h1050, 0, 1, 1, 4'd2, 0, 0));
    tbl.push_back(mk("m1_rst0",  1, 0, 1, 16'h10B0, 0, 1, 1, 4'd1, 0, 0));
    tbl.push_back(mk("m1_k1b",   1, 0, 1, 16'h1050, 0, 1, 1, 4'd2, 0, 0));
    tbl.push_back(mk("m1_bad",   1, 0, 1, 16'h1070, 0, 1, 1, 4'd0, 0, 0));
    tbl.push_back(mk("m1_badi",  1, 0, 1, 16'h1070, 0, 1, 0, 4'd0, 0, 0));
    run_tbl();
    full_key("m1_full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
